processor_controller: RTL and testbench



---
 rtl/processor_controller_if.sv | 56 +++++
 rtl/processor_controller.sv | 181 ++++++++++++++++++
 tb/tb_processor_controller.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/processor_controller_if.sv
// Control bundle between the processor controller and the 16-bit datapath.
//
// Purpose: carries the instruction register into the controller and every
// datapath control pin, debug state code and bring-up status signal out of it.
//
// Signals:
//   IR                     instruction register contents (datapath -> controller)
//   PC_clr, PC_up          program counter clear / increment
//   IR_ld                  load IR from instruction ROM
//   D_Addr, D_wr           data RAM address / write enable
//   RF_s                   register-file write-data select (1 = RAM, 0 = ALU)
//   RF_W_addr, RF_W_en     register-file write port
//   RF_Ra_addr, RF_Rb_addr register-file read port addresses
//   ALU_s0                 ALU function (0 pass A, 1 A+B, 2 A-B)
//   CurrentState,NextState debug state codes for the board mux
//   Halted, Instr_Count    bring-up status
//
// Handshake: there is no valid/ready pair here. Every control output is a
// level that the datapath samples on the next rising clk edge; IR is assumed
// stable except at the edge that ends a Fetch state.
//
// Modports: master = controller side, slave = datapath side.
interface processor_controller_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      IR;
  logic             PC_clr;
  logic             PC_up;
  logic             IR_ld;
  logic [7:0]       D_Addr;
  logic             D_wr;
  logic             RF_s;
  logic [3:0]       RF_W_addr;
  logic             RF_W_en;
  logic [3:0]       RF_Ra_addr;
  logic [3:0]       RF_Rb_addr;
  logic [2:0]       ALU_s0;
  logic [3:0]       CurrentState;
  logic [3:0]       NextState;
  logic             Halted;
  logic [CNT_W-1:0] Instr_Count;

  modport master (
    input  IR,
    output PC_clr, PC_up, IR_ld, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, CurrentState, NextState,
           Halted, Instr_Count
  );

  modport slave (
    output IR,
    input  PC_clr, PC_up, IR_ld, D_Addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, CurrentState, NextState,
           Halted, Instr_Count
  );
endinterface

// File: rtl/processor_controller.sv
// Moore control FSM for the 16-bit processor datapath.
//
// Purpose: sequences Fetch / Decode / execute states for the NOOP, STORE,
// LOAD, ADD, SUB and HALT instructions, drives the datapath control pins as a
// pure function of the current state and IR, and keeps a saturating count of
// retired instructions plus a halted flag.
//
// Ports:
//   clk    step clock
//   Reset  synchronous, active-high reset (highest priority)
//   bus    processor_controller_if.master: IR in, all control/debug out
//
// The interface instance must be built with the same CNT_W as this module.
module processor_controller #(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   Reset,
  processor_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       opcode;
  logic             retire;

  assign opcode = bus.IR[15:12];

  // Next-state logic. Reset is folded in here so NextState always shows the
  // code CurrentState will take at the coming edge.
  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;  // unused opcodes behave as NOOP
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP,
      S_STORE,
      S_LOAD_B,
      S_ADD,
      S_SUB:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;      // codes 10-15 recover to Init
    endcase
    if (Reset) begin
      state_d = S_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // An instruction retires on the edge that leaves its last execute state.
  // Halt is never left, so entering it is not counted.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_NOOP, S_STORE, S_LOAD_B, S_ADD, S_SUB: retire = 1'b1;
      default:                                 retire = 1'b0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (retire && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Moore outputs: a function of state_q and IR only. IR is read directly
  // (never copied) because the datapath only changes it at the Fetch edge.
  always_comb begin
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.IR_ld      = 1'b0;
    bus.D_Addr     = 8'h00;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = 4'h0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = 4'h0;
    bus.RF_Rb_addr = 4'h0;
    bus.ALU_s0     = 3'd0;
    bus.Halted     = 1'b0;
    case (state_q)
      S_INIT: begin
        bus.PC_clr = 1'b1;
      end
      S_FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      S_DECODE: begin
        // Present the RAM address a cycle early so a LOAD's synchronous read
        // is already under way when Load_A begins.
        bus.D_Addr = (opcode == OP_LOAD) ? bus.IR[11:4] : bus.IR[7:0];
      end
      S_LOAD_A: begin
        bus.D_Addr = bus.IR[11:4];
        bus.RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        bus.D_Addr    = bus.IR[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR[3:0];
        bus.RF_W_en   = 1'b1;
      end
      S_STORE: begin
        bus.D_Addr     = bus.IR[7:0];
        bus.D_wr       = 1'b1;
        bus.RF_Ra_addr = bus.IR[11:8];
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_addr = bus.IR[11:8];
        bus.RF_Rb_addr = bus.IR[7:4];
        bus.ALU_s0     = (state_q == S_SUB) ? 3'd2 : 3'd1;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = bus.IR[3:0];
        bus.RF_W_en    = 1'b1;
      end
      S_HALT: begin
        bus.Halted = 1'b1;
      end
      default: begin
        // illegal codes: every control output stays at 0
      end
    endcase
  end

  assign bus.CurrentState = state_q;
  assign bus.NextState    = state_d;
  assign bus.Instr_Count  = count_q;

endmodule

// File: tb/tb_processor_controller.sv
// Testbench for processor_controller.
//
// Two controllers share clk, Reset and IR: one with the default 16-bit
// instruction counter and one with a 6-bit counter so saturation is reachable
// quickly. A reference model tracks the expected state path of each
// instruction, the expected control outputs of each state, and the retired
// instruction count as a plain integer.
module tb_processor_controller;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        Reset;
  logic [15:0] ir;

  always #5 clk = ~clk;

  processor_controller_if #(.CNT_W(16)) bus_a ();
  processor_controller_if #(.CNT_W(6))  bus_b ();

  assign bus_a.IR = ir;
  assign bus_b.IR = ir;

  processor_controller #(.CNT_W(16)) u_dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus_a)
  );

  processor_controller #(.CNT_W(6)) u_dut6 (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus_b)
  );

  logic [29:0] outs_a, outs_b;
  assign outs_a = {bus_a.PC_clr, bus_a.PC_up, bus_a.IR_ld, bus_a.D_Addr,
                   bus_a.D_wr, bus_a.RF_s, bus_a.RF_W_addr, bus_a.RF_W_en,
                   bus_a.RF_Ra_addr, bus_a.RF_Rb_addr, bus_a.ALU_s0,
                   bus_a.Halted};
  assign outs_b = {bus_b.PC_clr, bus_b.PC_up, bus_b.IR_ld, bus_b.D_Addr,
                   bus_b.D_wr, bus_b.RF_s, bus_b.RF_W_addr, bus_b.RF_W_en,
                   bus_b.RF_Ra_addr, bus_b.RF_Rb_addr, bus_b.ALU_s0,
                   bus_b.Halted};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cnt     = 0;      // retired instructions since last reset
  logic [3:0] exp_q[$]; // expected state path of the current instruction

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t ir=%h)", tag, obs, exp,
               $time, ir);
    end
  endtask

  // Control pins the datapath needs in each state, in outs_* packing order.
  function automatic logic [29:0] exp_outs(input int st, input logic [15:0] i);
    logic       pc_clr, pc_up, ir_ld, d_wr, rf_s, w_en, halted;
    logic [7:0] d_addr;
    logic [3:0] w_addr, ra, rb;
    logic [2:0] alu;
    pc_clr = 0; pc_up = 0; ir_ld = 0; d_wr = 0; rf_s = 0; w_en = 0;
    halted = 0; d_addr = 0; w_addr = 0; ra = 0; rb = 0; alu = 0;
    case (st)
      0: pc_clr = 1;
      1: begin ir_ld = 1; pc_up = 1; end
      2: d_addr = (i[15:12] == 4'h2) ? i[11:4] : i[7:0];
      4: begin d_addr = i[11:4]; rf_s = 1; end
      5: begin d_addr = i[11:4]; rf_s = 1; w_addr = i[3:0]; w_en = 1; end
      6: begin d_addr = i[7:0]; d_wr = 1; ra = i[11:8]; end
      7, 8: begin
        ra = i[11:8]; rb = i[7:4]; w_addr = i[3:0]; w_en = 1;
        alu = (st == 8) ? 3'd2 : 3'd1;
      end
      9: halted = 1;
      default: ;
    endcase
    return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb,
            alu, halted};
  endfunction

  function automatic int sat(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input int st, input int nxt);
    check_eq("state",  {28'd0, bus_a.CurrentState}, st);
    check_eq("next",   {28'd0, bus_a.NextState},    nxt);
    check_eq("outs",   {2'd0, outs_a},              {2'd0, exp_outs(st, ir)});
    check_eq("count",  {16'd0, bus_a.Instr_Count},  sat(cnt, 65535));
    check_eq("state6", {28'd0, bus_b.CurrentState}, st);
    check_eq("outs6",  {2'd0, outs_b},              {2'd0, exp_outs(st, ir)});
    check_eq("count6", {26'd0, bus_b.Instr_Count},  sat(cnt, 63));
  endtask

  // Reset for two edges, release, and arrive in Fetch.
  task automatic do_reset();
    Reset = 1'b1;
    tick(); cnt = 0; check_state(0, 0);
    tick();          check_state(0, 0);
    Reset = 1'b0; #1; check_state(0, 1);
    tick();          check_state(1, 2);
  endtask

  // Called while in Fetch: presents ir and walks the expected path.
  task automatic run_instr(input logic [15:0] instr);
    logic is_halt;
    ir = instr;
    #1;
    exp_q.delete();
    exp_q.push_back(4'd2);
    case (instr[15:12])
      4'h1: exp_q.push_back(4'd6);
      4'h2: begin exp_q.push_back(4'd4); exp_q.push_back(4'd5); end
      4'h3: exp_q.push_back(4'd7);
      4'h4: exp_q.push_back(4'd8);
      4'h5: exp_q.push_back(4'd9);
      default: exp_q.push_back(4'd3);
    endcase
    is_halt = (instr[15:12] == 4'h5);
    for (int k = 0; k < exp_q.size(); k++) begin
      tick();
      check_state(exp_q[k],
                  (k + 1 < exp_q.size()) ? int'(exp_q[k+1]) : (is_halt ? 9 : 1));
    end
    if (!is_halt) begin
      tick();
      cnt++;
      check_state(1, 2);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] directed [5];
    logic [15:0] r;
    logic [3:0]  op;
    directed[0] = 16'h2A35;
    directed[1] = 16'h3214;
    directed[2] = 16'h4214;
    directed[3] = 16'h1C7E;
    directed[4] = 16'hF000;

    Reset = 1'b1;
    ir    = 16'h0000;
    do_reset();

    foreach (directed[d]) run_instr(directed[d]);

    // Halt holds for 20 edges with the count frozen; Reset leaves it.
    run_instr(16'h5000);
    for (int k = 0; k < 20; k++) begin
      tick();
      check_state(9, 9);
    end
    Reset = 1'b1; #1;
    check_state(9, 0);
    do_reset();

    // Reset during Load_A: Load_B must never be entered.
    ir = {4'h2, 12'($urandom_range(0, 4095))};
    tick(); check_state(2, 4);
    tick(); check_state(4, 5);
    Reset = 1'b1; #1;
    check_state(4, 0);
    tick(); cnt = 0; check_state(0, 0);
    Reset = 1'b0; #1; check_state(0, 1);
    tick();          check_state(1, 2);

    // 100 random non-HALT instructions; the 6-bit counter saturates at 63.
    for (int n = 0; n < 100; n++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd5) op = op + 4'd1;
      r = {op, 12'($urandom_range(0, 4095))};
      run_instr(r);
    end
    check_eq("sat6", {26'd0, bus_b.Instr_Count}, 32'd63);
    check_eq("cnt100", {16'd0, bus_a.Instr_Count}, 32'd100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
